// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared state encoding and default address map for mem_resp
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;
    localparam logic [31:0] DEFAULT_EXIT_ADDR = 32'hA000_0000;

endpackage

// File: rtl/mem_resp_sram.sv
// rtl/mem_resp_sram.sv - single-port word array with byte write enables and registered read
module mem_resp_sram #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_WIDTH   = 10
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic                    we,
    input  logic [IDX_WIDTH-1:0]    idx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    // Byte-masked write or registered read; rdata only changes on an enabled read
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < DATA_WIDTH/8; b++) begin
                    if (wstrb[b]) begin
                        mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/mem_resp.sv
// rtl/mem_resp.sv - request/response memory model with a simulation-exit register
module mem_resp
    import mem_resp_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(DEFAULT_BASE_ADDR),
    parameter logic [ADDR_WIDTH-1:0] EXIT_ADDR   = ADDR_WIDTH'(DEFAULT_EXIT_ADDR)
) (
    input  logic                    i_sys_clk,
    input  logic                    i_sys_rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_req_wstrb,
    output logic                    o_resp_valid,
    input  logic                    i_resp_ready,
    output logic [DATA_WIDTH-1:0]   o_resp_rdata,
    output logic                    o_resp_err,
    output logic                    o_end_flag,
    output logic [DATA_WIDTH-1:0]   o_end_data
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_WIDTH  = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH:0] ARRAY_BYTES = (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);

    state_t state;
    state_t state_next;

    logic                  accept;
    logic                  req_we_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0] req_wdata_q;
    logic [STRB_WIDTH-1:0] req_wstrb_q;

    logic [ADDR_WIDTH-1:0] addr_offset;
    logic                  aligned;
    logic                  hit_array;
    logic                  hit_exit;
    logic                  access_err;
    logic                  in_access;

    logic                  sram_en;
    logic [DATA_WIDTH-1:0] sram_rdata;

    logic                  resp_err_q;
    logic                  resp_from_sram_q;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic                  end_flag_q;
    logic [DATA_WIDTH-1:0] end_data_q;
    logic                  unused_bits;

    assign o_req_ready = (state == IDLE);
    assign accept      = i_req_valid && o_req_ready;
    assign in_access   = (state == ACCESS);

    // Decode works only on the captured request so later input changes are ignored
    assign addr_offset = req_addr_q - BASE_ADDR;
    assign aligned     = (req_addr_q[1:0] == 2'b00);
    assign hit_array   = aligned && (req_addr_q >= BASE_ADDR) && ({1'b0, addr_offset} < ARRAY_BYTES);
    assign hit_exit    = aligned && (req_addr_q == EXIT_ADDR);
    assign access_err  = !hit_array && !(hit_exit && (!req_we_q || (&req_wstrb_q)));
    assign unused_bits = ^addr_offset;

    // Reset gates the array enable so a write caught in ACCESS never commits
    assign sram_en = in_access && hit_array && !i_sys_rst;

    mem_resp_sram #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_WIDTH   (IDX_WIDTH)
    ) u_sram (
        .clk   (i_sys_clk),
        .en    (sram_en),
        .we    (req_we_q),
        .idx   (addr_offset[IDX_WIDTH+1:2]),
        .wdata (req_wdata_q),
        .wstrb (req_wstrb_q),
        .rdata (sram_rdata)
    );

    // State register with reset taking priority over every transition
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one access cycle, then hold the response until taken
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_req_valid) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    if (i_resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture the request on accept
    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst && accept) begin
            req_we_q    <= i_req_we;
            req_addr_q  <= i_req_addr;
            req_wdata_q <= i_req_wdata;
            req_wstrb_q <= i_req_wstrb;
        end
    end

    // Response attributes latched on the ACCESS->RESP edge and held through RESP
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            resp_err_q       <= 1'b0;
            resp_from_sram_q <= 1'b0;
            resp_data_q      <= '0;
        end else if (in_access) begin
            resp_err_q       <= access_err;
            resp_from_sram_q <= hit_array && !req_we_q;
            resp_data_q      <= (hit_exit && !req_we_q) ? DATA_WIDTH'(end_flag_q) : '0;
        end
    end

    // Sticky exit indication, set by a full-word write to the exit register
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            end_flag_q <= 1'b0;
            end_data_q <= '0;
        end else if (in_access && hit_exit && req_we_q && (&req_wstrb_q)) begin
            end_flag_q <= 1'b1;
            end_data_q <= req_wdata_q;
        end
    end

    assign o_resp_valid = (state == RESP);
    assign o_resp_err   = o_resp_valid && resp_err_q;
    assign o_resp_rdata = !o_resp_valid   ? '0 :
                          resp_from_sram_q ? sram_rdata : resp_data_q;
    assign o_end_flag   = end_flag_q;
    assign o_end_data   = end_data_q;

endmodule

// File: tb/tb_mem_resp.sv
// tb/tb_mem_resp.sv - scoreboard bench for mem_resp
module tb_mem_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        end_flag;
    logic [31:0] end_data;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   resp_seen = 0;

    mem_resp dut (
        .i_sys_clk    (clk),
        .i_sys_rst    (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_we     (req_we),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .i_req_wstrb  (req_wstrb),
        .o_resp_valid (resp_valid),
        .i_resp_ready (resp_ready),
        .o_resp_rdata (resp_rdata),
        .o_resp_err   (resp_err),
        .o_end_flag   (end_flag),
        .o_end_data   (end_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue one request; push the expected response on accept unless dropped
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [31:0] exp_rdata,
                          input logic exp_err, input bit push);
        int n = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_timeout", 32'(req_ready), 32'd1);
        if (push) exp_q.push_back('{exp_rdata, exp_err, cyc});
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = 32'h8000_0040;
        req_wdata = ~wdata;
        req_wstrb = 4'hF;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compares every presented response against the scoreboard head
    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid) begin
                check("req_ready_in_resp", 32'(req_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_resp: got rdata %h err %0d expected none", resp_rdata, resp_err);
                end else begin
                    if (!resp_seen) begin
                        check("latency", 32'(cyc - exp_q[0].acc), 32'd2);
                        resp_seen = 1;
                    end
                    check("rdata", resp_rdata, exp_q[0].rdata);
                    check("err", 32'(resp_err), 32'(exp_q[0].err));
                    if (resp_ready) begin
                        void'(exp_q.pop_front());
                        resp_seen = 0;
                    end
                end
            end else begin
                check("idle_rdata", resp_rdata, 32'd0);
                check("idle_err", 32'(resp_err), 32'd0);
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_end_flag", 32'(end_flag), 32'd0);
        check("rst_end_data", end_data, 32'd0);

        // Full write, readback, partial-strobe byte merge
        do_req(1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 1);
        do_req(0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 1);
        do_req(1, 32'h8000_0010, 32'h0000_55AA, 4'b0001, 32'h0, 0, 1);
        do_req(0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEAA, 0, 1);

        // Error cases and boundaries
        do_req(0, 32'h8000_0011, 32'h0, 4'h0, 32'h0, 1, 1);
        do_req(0, 32'h8000_1000, 32'h0, 4'h0, 32'h0, 1, 1);
        do_req(0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, 1, 1);
        do_req(1, 32'h8000_0012, 32'hFFFF_FFFF, 4'hF, 32'h0, 1, 1);
        do_req(1, 32'h8000_0FFC, 32'h1122_3344, 4'hF, 32'h0, 0, 1);
        do_req(0, 32'h8000_0FFC, 32'h0, 4'h0, 32'h1122_3344, 0, 1);
        do_req(1, 32'h8000_0010, 32'h0BAD_0BAD, 4'h0, 32'h0, 0, 1);
        do_req(0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEAA, 0, 1);

        // Exit register
        do_req(0, 32'hA000_0000, 32'h0, 4'h0, 32'h0, 0, 1);
        do_req(1, 32'hA000_0000, 32'h1, 4'h7, 32'h0, 1, 1);
        wait_done();
        check("end_flag_partial", 32'(end_flag), 32'd0);
        do_req(1, 32'hA000_0000, 32'h0, 4'hF, 32'h0, 0, 1);
        check("end_flag_in_access", 32'(end_flag), 32'd0);
        @(posedge clk); #1;
        check("end_flag_in_resp", 32'(end_flag), 32'd1);
        check("end_data", end_data, 32'd0);
        do_req(0, 32'hA000_0000, 32'h0, 4'h0, 32'h1, 0, 1);
        wait_done();

        // Backpressure: five stalled cycles, then handshake
        resp_ready = 1'b0;
        do_req(0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEAA, 0, 1);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("stall_valid", 32'(resp_valid), 32'd1);
        repeat (5) begin @(posedge clk); #1; end
        check("stall_still_valid", 32'(resp_valid), 32'd1);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_released", 32'(resp_valid), 32'd0);
        check("stall_ready_back", 32'(req_ready), 32'd1);
        wait_done();

        // Reset during a write in ACCESS
        do_req(1, 32'h8000_0020, 32'h1234_5678, 4'hF, 32'h0, 0, 1);
        wait_done();
        do_req(1, 32'h8000_0020, 32'hCAFE_F00D, 4'hF, 32'h0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_end_flag", 32'(end_flag), 32'd0);
        check("mid_rst_end_data", end_data, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("mid_rst_no_resp", 32'(resp_valid), 32'd0);
        end
        do_req(0, 32'h8000_0020, 32'h0, 4'h0, 32'h1234_5678, 0, 1);
        do_req(0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEAA, 0, 1);
        wait_done();
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
